obstacle_field: RTL and testbench
=================================

// Module: obstacle_field
// PURPOSE
//  Parametrised scrolling playfield generator and successor to the single-obstacle level block.
//  It holds NOBS obstacle slots that spawn at X_START in one of three LFSR-chosen lanes.
//  Every frame, each live obstacle scrolls left by a speed that ramps up over time.
//  The block also draws the scrolling dashed ground line. Its pixel outputs feed the VGA colour mux beside the duck sprite.
// PARAMETERS
//  CIDXW=3         colour index MSB (pixel outputs are CIDXW+1 bits)
//  CORDW=10        hc/vc/x coordinate width
//  NOBS=4          obstacle slots (1..8)
//  OBS_W=16        obstacle width, px
//  OBS_H=12        obstacle height, px
//  X_START=750     spawn x (left edge)
//  X_END=170       retire boundary
//  LANE0_Y=160     lane 0 top y
//  LANE1_Y=200     lane 1 top y
//  LANE2_Y=250     lane 2 top y
//  GROUND_Y=308    ground dash row (the row below it is drawn inverted)
//  SPAWN_FRAMES=45 frames between spawn attempts
//  RAMP_FRAMES=600 frames per speed increment
//  SPEED_MIN=2     initial speed, px/frame
//  SPEED_MAX=8     speed ceiling
// PORTS
//  CLK           in   1        system clock; the only clock
//  RESET         in   1        synchronous, active-high reset
//  state         in   4        game FSM state (encoding from shared package)
//  hc            in   CORDW    horizontal counter
//  vc            in   CORDW    vertical counter
//  level_pix     out  CIDXW+1  ground colour index, 0 = transparent
//  obstacle_pix  out  CIDXW+1  obstacle colour index, 0 = transparent
//  obs_valid     out  NOBS     live-slot mask (collision logic reads it)
//  speed         out  4        current scroll speed, px/frame
//  spawn_drop    out  1        1-cycle pulse: spawn lost because all slots are full
// BEHAVIOUR
//  Reset (sync): all slots invalid; frame and ramp counters 0; ground phase 0; speed = SPEED_MIN.
//    All other outputs are 0.
//  Mode decode:
//    RUN  = RUN1..DUCK2 (5..10)
//    HOLD = IDLE (11): everything frozen, pixels still drawn
//    CLR  = TITLE*/CHARSEL* (0-4,12,13): same effect as reset, except the LFSR keeps running
//  frame_tick: 1-cycle pulse on the first CLK where {hc,vc}=={0,0}, i.e. previous value != {0,0}.
//    hc/vc are held for several CLKs per pixel; only the first of those cycles produces a tick.
//  On frame_tick in RUN, all of the following update in the same cycle:
//   - Scroll: for each valid slot, if x < X_END+speed then clear valid; else x <= x-speed.
//     The unsigned compare guarantees x never wraps.
//   - Spawn: spawn_cnt increments. When it reaches SPAWN_FRAMES-1 it resets to 0 and a spawn fires:
//     lane = rand[12:0] % 3; x = X_START; written into the lowest-index slot that is invalid
//     after this tick's retire.
//     A slot retired on this tick may be reused on the same tick.
//     If no slot is free, nothing is written and spawn_drop pulses high for 1 cycle.
//   - Ramp: ramp_cnt increments. At RAMP_FRAMES-1 it resets and speed <= min(speed+1, SPEED_MAX).
//   - Ground phase: phase[2:0] <= phase - speed[2:0] (mod 8).
//  Pixels are registered, 1-CLK latency from hc/vc. Both pixel outputs are 0 outside RUN/HOLD
//    and outside hc 170..750.
//   - level_pix = 4'b0111 when (vc==GROUND_Y && hc[2:0]==phase) or (vc==GROUND_Y+1 && hc[2:0]!=phase); else 0.
//   - obstacle_pix = 4'b1000 when any valid slot has x <= hc < x+OBS_W and laneY <= vc < laneY+OBS_H; else 0.
//     Overlapping slots OR together; no priority.
//  RESET, or entering CLR, mid-frame clears everything on that edge; the next CLK outputs 0.
//  obs_valid and speed are direct register outputs (0 latency).
// STRUCTURE
//  Shared package (game_pkg): the state localparams (TITLE..CHARSEL1) and the RUN/HOLD/CLR decode function.
//  Sub-module: the existing LFSR (13-bit, .clock/.reset/.random), instantiated once.
//    Drive its reset from RESET only, not CLR.
//  Build the slot array with a generate loop. Lowest-free-slot selection is a priority encoder on ~valid_next.
// TESTING
//  1 Reset, state=RUN1, 46 frame ticks -> one slot valid, x=750-2*(ticks since spawn), lane in 0..2.
//  2 NOBS=2, SPAWN_FRAMES=2, speed 2 -> 3rd spawn while both slots live gives spawn_drop=1 for 1 cycle,
//    and obs_valid stays 2'b11.
//  3 Slot at x=171, speed=2 -> retired on next tick (171 < 172); x=172 -> x=170, retired on the tick after.
//  4 RAMP_FRAMES=4 -> speed 2,3,...,8 every 4 ticks, then holds at 8. Phase steps by -speed mod 8.
//  5 hc=x+15, vc=LANE1_Y+11, slot in lane 1 -> obstacle_pix=8 one CLK later;
//    hc=x+16 -> 0; vc=308, hc[2:0]==phase -> level_pix=7.
//  6 RUN -> IDLE: x frozen across ticks, pixels still drawn. IDLE -> TITLE: valid=0, speed=2 next CLK.
//    RESET pulsed mid-line -> all outputs 0.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared game state encoding and RUN/HOLD/CLR mode decode
package game_pkg;
  typedef enum logic [3:0] {
    TITLE0, TITLE1, TITLE2, TITLE3, TITLE4,
    RUN1, RUN2, JUMP1, JUMP2, DUCK1, DUCK2,
    IDLE, CHARSEL0, CHARSEL1
  } game_state_t;
  typedef enum logic [1:0] {MODE_CLR, MODE_RUN, MODE_HOLD} mode_t;
  function automatic mode_t decode_mode(input logic [3:0] s);
    return (s >= RUN1 && s <= DUCK2) ? MODE_RUN : (s == IDLE) ? MODE_HOLD : MODE_CLR;
  endfunction
endpackage

// File: rtl/obstacle_field_lfsr.sv
// obstacle_field_lfsr: 13-bit Fibonacci LFSR (x^13+x^4+x^3+x+1)
//   clock/reset in, random[12:0] out (current register state)
module obstacle_field_lfsr (
  input  logic        clock,
  input  logic        reset,
  output logic [12:0] random
);
  always_ff @(posedge clock)
    if (reset) random <= 13'h1;
    else random <= {random[11:0], random[12] ^ random[3] ^ random[2] ^ random[0]};
endmodule

// File: rtl/obstacle_field.sv
// obstacle_field: scrolling multi-obstacle playfield with ramping speed and dashed ground line
//   in : CLK, RESET (sync, active-high), state (game FSM), hc/vc (pixel counters)
//   out: level_pix/obstacle_pix (registered colour indices), obs_valid (slot mask),
//        speed (px/frame), spawn_drop (pulse when a spawn finds no free slot)
module obstacle_field
  import game_pkg::*;
#(
  parameter int CIDXW = 3,
  parameter int CORDW = 10,
  parameter int NOBS = 4,
  parameter int OBS_W = 16,
  parameter int OBS_H = 12,
  parameter int X_START = 750,
  parameter int X_END = 170,
  parameter int LANE0_Y = 160,
  parameter int LANE1_Y = 200,
  parameter int LANE2_Y = 250,
  parameter int GROUND_Y = 308,
  parameter int SPAWN_FRAMES = 45,
  parameter int RAMP_FRAMES = 600,
  parameter int SPEED_MIN = 2,
  parameter int SPEED_MAX = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       state,
  input  logic [CORDW-1:0] hc,
  input  logic [CORDW-1:0] vc,
  output logic [CIDXW:0]   level_pix,
  output logic [CIDXW:0]   obstacle_pix,
  output logic [NOBS-1:0]  obs_valid,
  output logic [3:0]       speed,
  output logic             spawn_drop
);
  localparam int W1 = CORDW + 1;
  localparam int SW = $clog2(SPAWN_FRAMES + 1);
  localparam int RW = $clog2(RAMP_FRAMES + 1);
  mode_t mode;
  logic [12:0] rnd;
  logic at_origin, origin_q, tick, spawn_fire, ramp_fire;
  logic [W1-1:0] hc1, vc1;
  logic [NOBS-1:0] valid_q, valid_d, keep, load, sel, hit;
  logic [CORDW-1:0] x_q [NOBS];
  logic [CORDW-1:0] x_d [NOBS];
  logic [1:0] lane_q [NOBS];
  logic [1:0] lane_d [NOBS];
  logic [W1-1:0] lane_top [NOBS];
  logic [1:0] lane_new;
  logic [SW-1:0] spawn_q, spawn_d;
  logic [RW-1:0] ramp_q, ramp_d;
  logic [3:0] speed_q, speed_d;
  logic [2:0] phase_q, phase_d;
  logic drop_d, drop_q, draw;
  logic [CIDXW:0] level_d, level_q, obst_d, obst_q;
  obstacle_field_lfsr u_lfsr (.clock(CLK), .reset(RESET), .random(rnd));
  assign mode = decode_mode(state);
  assign hc1 = {1'b0, hc};
  assign vc1 = {1'b0, vc};
  assign at_origin = hc == '0 && vc == '0;
  assign tick = at_origin && !origin_q && mode == MODE_RUN;
  assign lane_new = 2'(rnd % 13'd3);
  assign spawn_fire = tick && spawn_q == SW'(SPAWN_FRAMES - 1);
  assign ramp_fire = tick && ramp_q == RW'(RAMP_FRAMES - 1);
  // Lowest free slot after this tick's retire, isolated as a one-hot bit
  assign sel = ~keep & (keep + NOBS'(1));
  for (genvar i = 0; i < NOBS; i++) begin : g_slot
    assign keep[i] = valid_q[i] && !(tick && {1'b0, x_q[i]} < W1'(X_END) + W1'(speed_q));
    assign load[i] = spawn_fire && sel[i];
    assign valid_d[i] = keep[i] | load[i];
    assign x_d[i] = load[i] ? CORDW'(X_START) : (tick && keep[i]) ? x_q[i] - CORDW'(speed_q) : x_q[i];
    assign lane_d[i] = load[i] ? lane_new : lane_q[i];
    assign lane_top[i] = W1'(lane_q[i] == 2'd2 ? LANE2_Y : lane_q[i] == 2'd1 ? LANE1_Y : LANE0_Y);
    assign hit[i] = valid_q[i] && hc1 >= {1'b0, x_q[i]} && hc1 < {1'b0, x_q[i]} + W1'(OBS_W)
                    && vc1 >= lane_top[i] && vc1 < lane_top[i] + W1'(OBS_H);
  end
  assign spawn_d = !tick ? spawn_q : spawn_fire ? '0 : spawn_q + SW'(1);
  assign ramp_d = !tick ? ramp_q : ramp_fire ? '0 : ramp_q + RW'(1);
  assign speed_d = (ramp_fire && speed_q < 4'(SPEED_MAX)) ? speed_q + 4'd1 : speed_q;
  assign phase_d = tick ? phase_q - speed_q[2:0] : phase_q;
  assign drop_d = spawn_fire && &keep;
  assign draw = mode != MODE_CLR && hc1 >= W1'(X_END) && hc1 <= W1'(X_START);
  assign level_d = (draw && ((vc1 == W1'(GROUND_Y) && hc[2:0] == phase_q)
                   || (vc1 == W1'(GROUND_Y + 1) && hc[2:0] != phase_q))) ? (CIDXW+1)'(7) : '0;
  assign obst_d = (draw && |hit) ? (CIDXW+1)'(8) : '0;
  // Origin tracker runs in every mode so a tick is only the first cycle at {0,0}
  always_ff @(posedge CLK)
    if (RESET) origin_q <= 1'b1;
    else origin_q <= at_origin;
  always_ff @(posedge CLK) begin
    x_q <= x_d;
    lane_q <= lane_d;
    if (RESET || mode == MODE_CLR) begin
      valid_q <= '0;
      spawn_q <= '0;
      ramp_q <= '0;
      speed_q <= 4'(SPEED_MIN);
      phase_q <= '0;
      drop_q <= 1'b0;
      level_q <= '0;
      obst_q <= '0;
    end else begin
      valid_q <= valid_d;
      spawn_q <= spawn_d;
      ramp_q <= ramp_d;
      speed_q <= speed_d;
      phase_q <= phase_d;
      drop_q <= drop_d;
      level_q <= level_d;
      obst_q <= obst_d;
    end
  end
  assign level_pix = level_q;
  assign obstacle_pix = obst_q;
  assign obs_valid = valid_q;
  assign speed = speed_q;
  assign spawn_drop = drop_q;
endmodule

// File: tb/tb_obstacle_field.sv
// tb_obstacle_field: directed self-checking bench for obstacle_field (default and small configs)
module tb_obstacle_field;
  import game_pkg::*;
  logic CLK = 1'b0;
  logic RESET;
  logic [3:0] state_a, state_b;
  logic [9:0] hc, vc;
  logic [3:0] lvl_a, obs_a, lvl_b, obs_b, spd_a, spd_b;
  logic [3:0] val_a;
  logic [1:0] val_b;
  logic drop_a, drop_b;
  int checks = 0;
  int fails = 0;
  int lane_y, ph, sp;
  logic [2:0] lanes;
  always #5 CLK = ~CLK;
  obstacle_field u_a (
    .CLK(CLK), .RESET(RESET), .state(state_a), .hc(hc), .vc(vc),
    .level_pix(lvl_a), .obstacle_pix(obs_a), .obs_valid(val_a), .speed(spd_a), .spawn_drop(drop_a)
  );
  obstacle_field #(.NOBS(2), .SPAWN_FRAMES(2), .RAMP_FRAMES(4)) u_b (
    .CLK(CLK), .RESET(RESET), .state(state_b), .hc(hc), .vc(vc),
    .level_pix(lvl_b), .obstacle_pix(obs_b), .obs_valid(val_b), .speed(spd_b), .spawn_drop(drop_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic frame();
    hc = 10'd1; vc = 10'd0; step();
    hc = 10'd0; step();
  endtask
  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask
  task automatic at(input int h, input int v);
    hc = 10'(h); vc = 10'(v); step();
  endtask
  initial begin
    RESET = 1'b1; state_a = TITLE0; state_b = TITLE0; hc = 10'd5; vc = 10'd5;
    step(); step();
    chk("rst_valid", 32'(val_a), 0);
    chk("rst_speed", 32'(spd_a), 2);
    chk("rst_drop", 32'(drop_a), 0);
    chk("rst_lvl", 32'(lvl_a), 0);
    chk("rst_obs", 32'(obs_a), 0);
    RESET = 1'b0; state_a = RUN1;
    step();
    frames(44);
    chk("pre_spawn_valid", 32'(val_a), 0);
    frame();
    chk("spawn_valid", 32'(val_a), 1);
    lanes = '0;
    at(750, 160); lanes[0] = obs_a == 4'd8;
    at(750, 200); lanes[1] = obs_a == 4'd8;
    at(750, 250); lanes[2] = obs_a == 4'd8;
    chk("one_lane", 32'($countones(lanes)), 1);
    lane_y = lanes[2] ? 250 : lanes[1] ? 200 : 160;
    frame();
    chk("t46_valid", 32'(val_a), 1);
    at(748, lane_y); chk("t46_left", 32'(obs_a), 8);
    at(747, lane_y); chk("t46_out_left", 32'(obs_a), 0);
    at(748, lane_y + 11); chk("t46_bottom", 32'(obs_a), 8);
    at(748, lane_y + 12); chk("t46_below", 32'(obs_a), 0);
    at(172, 308); chk("gnd_ph4", 32'(lvl_a), 7);
    at(173, 308); chk("gnd_ph4_off", 32'(lvl_a), 0);
    at(173, 309); chk("gnd_inv_on", 32'(lvl_a), 7);
    at(172, 309); chk("gnd_inv_off", 32'(lvl_a), 0);
    state_a = IDLE;
    frames(3);
    chk("hold_valid", 32'(val_a), 1);
    at(748, lane_y); chk("hold_left", 32'(obs_a), 8);
    at(747, lane_y); chk("hold_out_left", 32'(obs_a), 0);
    at(172, 308); chk("hold_gnd", 32'(lvl_a), 7);
    at(174, 308); chk("hold_gnd_off", 32'(lvl_a), 0);
    state_a = RUN1;
    frames(54);
    chk("t100_valid", 32'(val_a), 4'b0011);
    at(655, lane_y + 11); chk("t100_xw_m1", 32'(obs_a), 8);
    at(656, lane_y + 11); chk("t100_xw", 32'(obs_a), 0);
    at(640, lane_y); chk("t100_corner", 32'(obs_a), 8);
    at(639, lane_y); chk("t100_left_out", 32'(obs_a), 0);
    frames(124);
    chk("t224_valid", 32'(val_a), 4'b1111);
    chk("t224_nodrop", 32'(drop_a), 0);
    frame();
    chk("t225_drop", 32'(drop_a), 1);
    chk("t225_valid", 32'(val_a), 4'b1111);
    step();
    chk("t225_drop_end", 32'(drop_a), 0);
    frames(109);
    at(172, lane_y); chk("x172_left", 32'(obs_a), 8);
    at(171, lane_y); chk("x172_out", 32'(obs_a), 0);
    at(187, lane_y); chk("x172_right", 32'(obs_a), 8);
    at(188, lane_y); chk("x172_past", 32'(obs_a), 0);
    frame();
    chk("x170_valid", 32'(val_a), 4'b1111);
    at(170, lane_y); chk("x170_left", 32'(obs_a), 8);
    at(185, lane_y); chk("x170_right", 32'(obs_a), 8);
    at(186, lane_y); chk("x170_past", 32'(obs_a), 0);
    frame();
    chk("retire_valid", 32'(val_a), 4'b1110);
    at(170, lane_y); chk("retire_pix", 32'(obs_a), 0);
    at(176, 308); chk("pre_rst_gnd", 32'(lvl_a), 7);
    RESET = 1'b1; step(); RESET = 1'b0;
    chk("mid_rst_lvl", 32'(lvl_a), 0);
    chk("mid_rst_obs", 32'(obs_a), 0);
    chk("mid_rst_valid", 32'(val_a), 0);
    chk("mid_rst_speed", 32'(spd_a), 2);
    chk("mid_rst_drop", 32'(drop_a), 0);
    state_a = TITLE0; state_b = RUN1;
    step();
    sp = 2; ph = 0;
    for (int t = 1; t <= 32; t++) begin
      frame();
      ph = (ph - sp) & 7;
      if (t % 4 == 0 && sp < 8) sp++;
      chk($sformatf("ramp_speed_t%0d", t), 32'(spd_b), 32'(sp));
      if (t == 1) chk("b_t1_valid", 32'(val_b), 2'b00);
      if (t == 2) chk("b_t2_valid", 32'(val_b), 2'b01);
      if (t == 4) chk("b_t4_valid", 32'(val_b), 2'b11);
      if (t == 6) begin
        chk("b_drop", 32'(drop_b), 1);
        chk("b_drop_valid", 32'(val_b), 2'b11);
        step();
        chk("b_drop_end", 32'(drop_b), 0);
      end
    end
    at(200 + ph, 308); chk("b_gnd_on", 32'(lvl_b), 7);
    at(200 + ((ph + 1) & 7), 308); chk("b_gnd_off", 32'(lvl_b), 0);
    at(200 + ((ph + 1) & 7), 309); chk("b_gnd_inv", 32'(lvl_b), 7);
    state_b = IDLE;
    frames(2);
    chk("b_hold_speed", 32'(spd_b), 8);
    at(200 + ph, 308); chk("b_hold_gnd", 32'(lvl_b), 7);
    at(200 + ((ph - 1) & 7), 308); chk("b_hold_gnd_off", 32'(lvl_b), 0);
    hc = 10'(200 + ph); vc = 10'd308; state_b = TITLE0; step();
    chk("b_clr_speed", 32'(spd_b), 2);
    chk("b_clr_valid", 32'(val_b), 0);
    chk("b_clr_lvl", 32'(lvl_b), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
